// File: rtl/ladder_pkg.sv
// Shared types and constants for the ladder (triangle) counter link receiver.
package ladder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RISE,
        FALL
    } ladder_state_t;

    localparam int LADDER_MIN_DELTA = 2;

endpackage

// File: rtl/ladder_report_reg.sv
// Peak report holding register: valid/ready hold, drop-on-pending and sticky overrun.
module ladder_report_reg #(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              peak_valid,
    input  logic [WIDTH-1:0]  peak_delta,
    input  logic [PWIDTH-1:0] peak_period,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_delta,
    output logic [PWIDTH-1:0] out_period,
    output logic              overrun
);

    // A handshake in the same cycle as a new peak frees the slot for it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_delta  <= '0;
            out_period <= '0;
            overrun    <= 1'b0;
        end else if (peak_valid) begin
            if (!out_valid || out_ready) begin
                out_valid  <= 1'b1;
                out_delta  <= peak_delta;
                out_period <= peak_period;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ladder_decoder.sv
// Receive end of the ladder counter link: tracks the triangle stream, recovers
// the peak and period, and flags protocol violations.
module ladder_decoder
    import ladder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_delta,
    output logic [PWIDTH-1:0] out_period,
    output logic              locked,
    output logic              dir,
    output logic              err,
    output logic              overrun
);

    localparam logic signed [WIDTH:0] STEP_UP   = 1;
    localparam logic signed [WIDTH:0] STEP_DOWN = -1;
    localparam logic signed [WIDTH:0] STEP_FLAT = 0;

    ladder_state_t      state;
    ladder_state_t      state_next;
    logic [WIDTH-1:0]   prev;
    logic [PWIDTH-1:0]  pcnt;
    logic               seen_peak;
    logic signed [WIDTH:0] step;
    logic               bad;
    logic               peak;
    logic               to_start;
    logic [PWIDTH-1:0]  peak_period;

    // Extra sign bit keeps 15->0 a large negative step rather than a wrap to +1.
    assign step = $signed({1'b0, in_value}) - $signed({1'b0, prev});
    assign peak_period = seen_peak ? pcnt : '0;

    always_comb begin
        state_next = state;
        bad        = 1'b0;
        peak       = 1'b0;
        to_start   = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    state_next = START;
                    to_start   = 1'b1;
                end
                START: begin
                    if (step == STEP_UP)        state_next = RISE;
                    else if (step == STEP_DOWN) state_next = FALL;
                    else                        bad = 1'b1;
                end
                RISE: begin
                    if (step == STEP_DOWN) begin
                        if (prev >= WIDTH'(LADDER_MIN_DELTA)) begin
                            peak       = 1'b1;
                            state_next = FALL;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (step != STEP_UP) begin
                        bad = 1'b1;
                    end
                end
                FALL: begin
                    if (step == STEP_DOWN && in_value != '0) state_next = FALL;
                    else if (step == STEP_FLAT && prev == WIDTH'(1)) state_next = RISE;
                    else bad = 1'b1;
                end
                default: state_next = IDLE;
            endcase
            if (bad) state_next = START;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            prev      <= '0;
            pcnt      <= '0;
            seen_peak <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
            dir       <= 1'b0;
        end else begin
            state <= state_next;
            err   <= bad;
            dir   <= (state_next == RISE);
            if (bad)       locked <= 1'b0;
            else if (peak) locked <= 1'b1;
            if (in_valid) begin
                prev <= in_value;
                // The first peak after a resync has no predecessor, so it reports 0.
                if (bad || to_start) begin
                    pcnt      <= '0;
                    seen_peak <= 1'b0;
                end else if (peak) begin
                    pcnt      <= PWIDTH'(1);
                    seen_peak <= 1'b1;
                end else if (pcnt != '1) begin
                    pcnt <= pcnt + 1'b1;
                end
            end
        end
    end

    ladder_report_reg #(
        .WIDTH (WIDTH),
        .PWIDTH(PWIDTH)
    ) u_report (
        .clk        (clk),
        .resetn     (resetn),
        .peak_valid (peak),
        .peak_delta (prev),
        .peak_period(peak_period),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_delta  (out_delta),
        .out_period (out_period),
        .overrun    (overrun)
    );

endmodule
